paddle_tracker: RTL and testbench

- Sits between a read_potentiometer instance and the game state machine; one instance per player.
- Conditions the raw 8-bit potentiometer value into the paddle's top-edge Y coordinate.
- Pipeline: windowed averaging, 2x scaling, low deadzone, clamp to the playfield, hysteresis, then a per-frame slew-rate limit.
- The game logic reads pos once per frame instead of doing deadzone/clamp inline.

---
 rtl/pong_pkg.sv | 18 +
 rtl/window_average.sv | 50 +++++
 rtl/paddle_tracker.sv | 103 ++++++++++
 tb/tb_paddle_tracker.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the pong game: screen geometry, paddle conditioning
// defaults and the paddle tracker FSM encodings.
package pong_pkg;

    localparam int SCREEN_H = 480;
    localparam int PADDLE_H = 50;
    localparam int MAX_POS  = SCREEN_H - PADDLE_H;
    localparam int DEADZONE = 41;

    localparam logic [2:0] S_FILL  = 3'b001;
    localparam logic [2:0] S_SNAP  = 3'b010;
    localparam logic [2:0] S_TRACK = 3'b100;

    function automatic logic [9:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/window_average.sv
// Averages fixed-size windows of 8-bit samples; done pulses the cycle after
// the last sample of a window has been absorbed.
module window_average #(
    parameter int AVG_LOG2 = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic [7:0] avg,
    output logic       done
);

    localparam int SUM_W = 8 + AVG_LOG2;

    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    sum_next;
    logic [AVG_LOG2-1:0] count;

    assign sum_next = sum + SUM_W'(in);

    // The final sample is folded into avg directly so the accumulator can
    // restart on the same edge without losing a cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum   <= '0;
            count <= '0;
            avg   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clr) begin
                sum   <= '0;
                count <= '0;
            end else if (in_valid) begin
                if (count == '1) begin
                    avg   <= sum_next[SUM_W-1:AVG_LOG2];
                    sum   <= '0;
                    count <= '0;
                    done  <= 1'b1;
                end else begin
                    sum   <= sum_next;
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/paddle_tracker.sv
// Turns raw potentiometer samples into a paddle top-edge Y coordinate:
// average, scale, deadzone, clamp, hysteresis and per-frame slew limiting.
module paddle_tracker #(
    parameter int AVG_LOG2 = 3,
    parameter int DEADZONE = pong_pkg::DEADZONE,
    parameter int MAX_POS  = pong_pkg::MAX_POS,
    parameter int HYST     = 2,
    parameter int SLEW_MAX = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sample,
    input  logic       sample_valid,
    input  logic       frame_tick,
    input  logic       enable,
    output logic [9:0] pos,
    output logic       pos_valid,
    output logic       locked
);

    import pong_pkg::*;

    logic [7:0] avg;
    logic       done;
    logic [2:0] state;
    logic [9:0] target;
    logic [9:0] scaled;
    logic [9:0] new_target;
    logic [9:0] step;
    logic [9:0] slewed;

    window_average #(.AVG_LOG2(AVG_LOG2)) u_window_average (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (~enable),
        .in_valid (sample_valid),
        .in       (sample),
        .avg      (avg),
        .done     (done)
    );

    always_comb begin
        scaled = {1'b0, avg, 1'b0};
        if (scaled < 10'(DEADZONE)) begin
            new_target = '0;
        end else if ((scaled - 10'(DEADZONE)) > 10'(MAX_POS)) begin
            new_target = 10'(MAX_POS);
        end else begin
            new_target = scaled - 10'(DEADZONE);
        end
    end

    always_comb begin
        step   = (abs_diff(target, pos) > 10'(SLEW_MAX)) ? 10'(SLEW_MAX) : abs_diff(target, pos);
        slewed = (target > pos) ? (pos + step) : (pos - step);
    end

    // Slewing reads the registered target, so a target change landing on a
    // frame_tick edge only takes effect from the following frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_FILL;
            target    <= '0;
            pos       <= '0;
            pos_valid <= 1'b0;
            locked    <= 1'b0;
        end else begin
            pos_valid <= 1'b0;
            if (enable) begin
                case (state)
                    S_FILL: begin
                        if (done) begin
                            target <= new_target;
                            state  <= S_SNAP;
                        end
                    end
                    S_SNAP: begin
                        if (done) begin
                            target <= new_target;
                        end
                        if (frame_tick) begin
                            pos       <= target;
                            pos_valid <= 1'b1;
                            locked    <= 1'b1;
                            state     <= S_TRACK;
                        end
                    end
                    S_TRACK: begin
                        if (done && (abs_diff(new_target, target) > 10'(HYST))) begin
                            target <= new_target;
                        end
                        if (frame_tick) begin
                            pos       <= slewed;
                            pos_valid <= 1'b1;
                        end
                    end
                    default: state <= S_FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_paddle_tracker.sv
// Randomised plus directed bench for paddle_tracker, checked every cycle
// against a behavioural model of the conditioning rules.
module tb_paddle_tracker;

    logic       clk;
    logic       reset_n;
    logic [7:0] sample;
    logic       sample_valid;
    logic       frame_tick;
    logic       enable;
    logic [9:0] pos;
    logic       pos_valid;
    logic       locked;

    int vectors;
    int miscompares;

    int m_win[$];
    bit m_done;
    int m_avg;
    int m_target;
    bit m_have_target;
    bit m_locked;
    int m_pos;
    bit m_pv;

    paddle_tracker dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .frame_tick   (frame_tick),
        .enable       (enable),
        .pos          (pos),
        .pos_valid    (pos_valid),
        .locked       (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int target_of(input int a);
        int sc;
        sc = a * 2;
        if (sc < 41) return 0;
        return (sc - 41 > 430) ? 430 : sc - 41;
    endfunction

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_win.delete();
        m_done = 0;
        m_avg = 0;
        m_target = 0;
        m_have_target = 0;
        m_locked = 0;
        m_pos = 0;
        m_pv = 0;
    endfunction

    function automatic void model_step(input bit sv, input int s, input bit ft, input bit en);
        int t0;
        bit lk;
        bit ht;
        int n;
        int sum;
        t0 = m_target;
        lk = m_locked;
        ht = m_have_target;
        m_pv = 0;
        if (!en) begin
            m_win.delete();
            m_done = 0;
            return;
        end
        if (m_done) begin
            n = target_of(m_avg);
            if (!lk) begin
                m_target = n;
                m_have_target = 1;
            end else if ((n > m_target ? n - m_target : m_target - n) > 2) begin
                m_target = n;
            end
        end
        if (ft) begin
            if (lk) begin
                if (t0 > m_pos) m_pos = m_pos + min_int(t0 - m_pos, 8);
                else if (t0 < m_pos) m_pos = m_pos - min_int(m_pos - t0, 8);
                m_pv = 1;
            end else if (ht) begin
                m_pos = t0;
                m_pv = 1;
                m_locked = 1;
            end
        end
        m_done = 0;
        if (sv) begin
            m_win.push_back(s);
            if (m_win.size() == 8) begin
                sum = 0;
                foreach (m_win[i]) sum += m_win[i];
                m_avg = sum / 8;
                m_done = 1;
                m_win.delete();
            end
        end
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit sv, input int s, input bit ft, input bit en);
        sample_valid = sv;
        sample       = 8'(s);
        frame_tick   = ft;
        enable       = en;
        @(posedge clk);
        model_step(sv, s, ft, en);
        #1;
        checkOutput("pos", int'(pos), m_pos);
        checkOutput("pos_valid", int'(pos_valid), int'(m_pv));
        checkOutput("locked", int'(locked), int'(m_locked));
        checkOutput("pos_le_max", int'(pos <= 10'd430), 1);
    endtask

    task automatic do_reset();
        sample_valid = 1'b0;
        frame_tick   = 1'b0;
        sample       = 8'd0;
        enable       = 1'b1;
        reset_n      = 1'b0;
        #1;
        model_reset();
        checkOutput("reset_pos", int'(pos), 0);
        checkOutput("reset_pos_valid", int'(pos_valid), 0);
        checkOutput("reset_locked", int'(locked), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic feed_window(input int val);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, val, 0, 1);
            applyStimulus(0, 0, 0, 1);
        end
        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
    endtask

    task automatic tick();
        applyStimulus(0, 0, 1, 1);
    endtask

    initial begin
        int level;
        int en_off;
        int s;
        vectors     = 0;
        miscompares = 0;
        reset_n      = 1'b1;
        sample_valid = 1'b0;
        frame_tick   = 1'b0;
        sample       = 8'd0;
        enable       = 1'b1;
        #2;
        do_reset();

        // basic lock, frame_ticks before lock produce nothing
        tick();
        checkOutput("prelock_pos_valid", int'(pos_valid), 0);
        feed_window(128);
        tick();
        checkOutput("lock_pos", int'(pos), 215);
        checkOutput("lock_pos_valid", int'(pos_valid), 1);
        checkOutput("lock_locked", int'(locked), 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("lock_pv_one_cycle", int'(pos_valid), 0);

        // slew up into the clamp, then all the way down
        feed_window(255);
        for (int i = 0; i < 26; i++) tick();
        checkOutput("slew_tick26", int'(pos), 423);
        tick();
        checkOutput("slew_clamp", int'(pos), 430);
        tick();
        checkOutput("slew_hold_max", int'(pos), 430);
        feed_window(0);
        for (int i = 0; i < 53; i++) tick();
        checkOutput("slew_down_tick53", int'(pos), 6);
        tick();
        checkOutput("slew_down_zero", int'(pos), 0);

        // deadzone and hysteresis
        feed_window(128);
        for (int i = 0; i < 27; i++) tick();
        checkOutput("rise_215", int'(pos), 215);
        feed_window(20);
        for (int i = 0; i < 27; i++) tick();
        checkOutput("deadzone_zero", int'(pos), 0);
        feed_window(128);
        for (int i = 0; i < 27; i++) tick();
        feed_window(129);
        tick();
        checkOutput("hyst_hold", int'(pos), 215);
        feed_window(130);
        tick();
        checkOutput("hyst_move", int'(pos), 219);

        // done coincident with frame_tick slews toward the old target
        for (int i = 0; i < 7; i++) applyStimulus(1, 255, 0, 1);
        applyStimulus(1, 255, 0, 1);
        applyStimulus(0, 0, 1, 1);
        checkOutput("simul_old_target", int'(pos), 219);
        tick();
        checkOutput("simul_new_target", int'(pos), 227);

        // averaging of a split window
        do_reset();
        for (int i = 0; i < 8; i++) applyStimulus(1, (i < 4) ? 0 : 255, 0, 1);
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("avg_pos", int'(pos), 213);

        // partial window discarded by enable low
        for (int i = 0; i < 3; i++) applyStimulus(1, 255, 0, 1);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        tick();
        checkOutput("enable_partial_hold", int'(pos), 213);

        // reset in the middle of a window
        for (int i = 0; i < 5; i++) applyStimulus(1, 200, 0, 1);
        do_reset();
        feed_window(128);
        tick();
        checkOutput("relock_pos", int'(pos), 215);

        // randomised traffic against the model
        level  = 128;
        en_off = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if ((cyc % 150) == 0) begin
                case ($urandom_range(0, 3))
                    0: level = $urandom_range(0, 22);
                    1: level = $urandom_range(240, 255);
                    default: level = $urandom_range(0, 255);
                endcase
            end
            if (en_off == 0 && $urandom_range(0, 99) == 0) en_off = $urandom_range(1, 6);
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                s = level + $urandom_range(0, 6) - 3;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                applyStimulus($urandom_range(0, 2) == 0, s, $urandom_range(0, 15) == 0, en_off == 0);
                if (en_off > 0) en_off--;
            end
        end

        sample_valid = 1'b0;
        frame_tick   = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
